// File: rtl/obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : obi_mem_responder
// Brief   : OBI data-memory responder; word RAM with byte-enable writes,
//           configurable grant wait states, one outstanding transaction.
// Revision: 1.0 - initial release
// ============================================================================
module obi_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned c_addr_w = $clog2(DEPTH);
    localparam logic [3:0]  c_wait   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_gnt;
    logic                  w_in_range;
    logic [c_addr_w-1:0]   w_idx;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];
    logic                  w_unused_addr;

    assign w_in_range    = (data_addr_i[31:c_addr_w+2] == '0);
    assign w_idx         = data_addr_i[c_addr_w+1:2];
    assign w_unused_addr = ^data_addr_i[1:0];

    // IDLE and RESP react identically to a new request; only WAIT counts.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_gnt        = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (!data_req_i) begin
                    w_state_next = S_IDLE;
                end else if (c_wait == 4'd0) begin
                    w_gnt        = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = 4'd1;
                end
            end
            S_WAIT: begin
                if (!data_req_i) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt != c_wait) begin
                    w_cnt_next = r_cnt + 4'd1;
                end else begin
                    w_gnt        = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // No handshake (and hence no RAM access) can happen under reset.
        if (reset) begin
            w_gnt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_gnt) begin
                r_err   <= !w_in_range;
                r_rdata <= (w_in_range && !data_we_i) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_gnt && data_we_i && w_in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (data_be_i[n]) begin
                    r_mem[w_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
                end
            end
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = (r_state == S_RESP) && !reset;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_obi_mem_responder
// Brief   : Scoreboard bench for obi_mem_responder with a zero-wait and a
//           three-wait instance, random traffic checked against a word model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_obi_mem_responder;

    localparam int c_depth0 = 1024;
    localparam int c_depth1 = 64;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, gnt, we, rvalid, err;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  be    [2];

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] mdl [2][1024];

    obi_mem_responder #(.DEPTH(c_depth0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_addr_i(addr[0]),
        .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0])
    );

    obi_mem_responder #(.DEPTH(c_depth1), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_addr_i(addr[1]),
        .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth_of(input int d);
        return (d == 0) ? c_depth0 : c_depth1;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected rvalid", 32'(d + 1), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rvalid instance", 32'(d), 32'(e.inst));
                    check("rvalid cycle", 32'(cyc), 32'(e.due));
                    check("rdata", rdata[d], e.rd);
                    check("err", 32'(err[d]), 32'(e.err));
                end
            end
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
            check("missing rvalid", 32'd0, 32'(sb[0].due));
            void'(sb.pop_front());
        end
    end

    // Issue one request (caller sits just after a rising edge); req stays high.
    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
        int   waits = 0;
        exp_t e;
        int   idx;
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        @(negedge clk);
        while (gnt[d] !== 1'b1 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check("req->gnt latency", 32'(waits), 32'(wait_of(d)));
        if (gnt[d] === 1'b1) begin
            e.inst = d;
            e.due  = cyc + 1;
            if (a >= 32'(depth_of(d) * 4)) begin
                e.rd  = 32'd0;
                e.err = 1'b1;
            end else begin
                idx   = int'(a / 4);
                e.err = 1'b0;
                if (w) begin
                    for (int n = 0; n < 4; n++)
                        if (b[n]) mdl[d][idx][8*n +: 8] = wd[8*n +: 8];
                    e.rd = 32'd0;
                end else begin
                    e.rd = mdl[d][idx];
                end
            end
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d, input int n);
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom;
        be[d] = 4'($urandom); wdata[d] = $urandom;
        repeat (n) begin
            @(negedge clk);
            check("gnt while req low", 32'(gnt[d]), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_txn(input int d);
        logic [31:0] a;
        int          sel = $urandom_range(0, 9);
        if (sel == 0)      a = 32'(depth_of(d) * 4) + 32'($urandom_range(0, 255));
        else if (sel == 1) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        else               a = 32'($urandom_range(0, depth_of(d) * 4 - 1));
        txn(d, 1'($urandom), a, 4'($urandom), $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h10; be[d] = 4'hF; wdata[d] = 32'h1234_5678;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("reset gnt", 32'(gnt[d]), 32'd0);
                check("reset rvalid", 32'(rvalid[d]), 32'd0);
                if (c == 1) begin
                    check("reset rdata", rdata[d], 32'd0);
                    check("reset err", 32'(err[d]), 32'd0);
                end
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle(0, 1);
        idle(1, 1);

        // Fill both memories so every in-range read has a known value.
        for (int i = 0; i < c_depth0; i++) txn(0, 1'b1, 32'(i * 4), 4'hF, $urandom);
        idle(0, 2);
        for (int i = 0; i < c_depth1; i++) txn(1, 1'b1, 32'(i * 4), 4'hF, $urandom);
        idle(1, 2);

        // Zero-wait directed cases.
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF); idle(0, 1);
        txn(0, 1'b0, 32'h10, 4'h0, 32'h0);         idle(0, 1);
        txn(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
        txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        txn(0, 1'b0, 32'h23, 4'h0, 32'h0);         idle(0, 1);
        txn(0, 1'b1, 32'(c_depth0 * 4), 4'hF, 32'h5A5A_5A5A);
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0);
        txn(0, 1'b0, 32'(c_depth0 * 4 - 4), 4'hF, 32'h0);
        idle(0, 1);

        // Streaming reads: one response per cycle.
        for (int i = 0; i < 8; i++) txn(0, 1'b0, 32'($urandom_range(0, c_depth0 * 4 - 1)), 4'hF, 32'h0);
        idle(0, 2);

        for (int i = 0; i < 250; i++) begin
            rand_txn(0);
            if ($urandom_range(0, 2) == 0) idle(0, $urandom_range(1, 2));
        end
        idle(0, 2);

        // Reset in the response cycle swallows the pending rvalid.
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0);
        void'(sb.pop_back());
        reset = 1'b1; req[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rvalid after mid-op reset", 32'(rvalid[0]), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle(0, 1);
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0); idle(0, 1);

        // Three-wait instance: latency, abandoned requests, random traffic.
        txn(1, 1'b0, 32'h10, 4'hF, 32'h0); idle(1, 1);
        for (int k = 1; k <= 3; k++) begin
            req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0; be[1] = 4'hF; wdata[1] = 32'hFFFF_FFFF;
            repeat (k) begin
                @(negedge clk);
                check("gnt before wait expires", 32'(gnt[1]), 32'd0);
                @(posedge clk); #1;
            end
            idle(1, 4);
        end
        txn(1, 1'b1, 32'(c_depth1 * 4), 4'hF, 32'h5A5A_5A5A);
        txn(1, 1'b0, 32'h0, 4'hF, 32'h0);
        idle(1, 1);
        for (int i = 0; i < 150; i++) begin
            rand_txn(1);
            if ($urandom_range(0, 2) == 0) idle(1, $urandom_range(1, 2));
        end
        idle(1, 3);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
